// File: rtl/discrete_range_sampler.sv
// Draws a uniformly distributed range index for a discrete variable and returns the
// [start,end] pair stored at that index; rejection sampling with a bounded retry fallback.
module discrete_range_sampler #(
  parameter int NUM_VARIABLES     = 16,
  parameter int VAR_INDEX_WIDTH   = 4,
  parameter int MAX_RANGES        = 8,
  parameter int RANGE_INDEX_WIDTH = 3,
  parameter int VALUE_WIDTH       = 16,
  parameter int MAX_RETRIES       = 7
) (
  input  logic                                in_clock,
  input  logic                                in_reset,
  input  logic                                in_seed_load,
  input  logic [15:0]                         in_seed,
  input  logic                                in_request,
  input  logic [VAR_INDEX_WIDTH-1:0]          in_variable_index,
  input  logic                                in_exclude_current,
  input  logic [RANGE_INDEX_WIDTH-1:0]        in_current_index,
  input  logic                                in_size_write,
  input  logic [VAR_INDEX_WIDTH-1:0]          in_write_variable,
  input  logic [RANGE_INDEX_WIDTH-1:0]        in_write_range,
  input  logic [RANGE_INDEX_WIDTH:0]          in_size_value,
  input  logic                                in_range_write,
  input  logic signed [VALUE_WIDTH-1:0]       in_write_start,
  input  logic signed [VALUE_WIDTH-1:0]       in_write_end,
  output logic                                out_busy,
  output logic                                out_valid,
  output logic                                out_error,
  output logic [RANGE_INDEX_WIDTH-1:0]        out_range_index,
  output logic signed [VALUE_WIDTH-1:0]       out_start,
  output logic signed [VALUE_WIDTH-1:0]       out_end,
  output logic                                out_equal
);

  localparam int CW  = RANGE_INDEX_WIDTH + 1;
  localparam int RTW = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [CW-1:0]              MAX_COUNT   = CW'(MAX_RANGES);
  localparam logic [RTW-1:0]             RETRY_LIMIT = RTW'(MAX_RETRIES);
  localparam logic [VAR_INDEX_WIDTH:0]   VAR_LIMIT   = (VAR_INDEX_WIDTH + 1)'(NUM_VARIABLES);
  localparam logic [15:0]                LFSR_SEED   = 16'hACE1;
  localparam logic [15:0]                LFSR_TAPS   = 16'hB400;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_DRAW, S_DONE} state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] v);
    return (v > MAX_COUNT) ? MAX_COUNT : v;
  endfunction

  state_t state_q, state_d;

  logic [15:0]                   lfsr_q, lfsr_d;
  logic [VAR_INDEX_WIDTH-1:0]    var_q, var_d;
  logic                          mode_q, mode_d;
  logic [RANGE_INDEX_WIDTH-1:0]  cur_q, cur_d;
  logic [CW-1:0]                 count_q, count_d;
  logic [RTW-1:0]                retry_q, retry_d;
  logic [RANGE_INDEX_WIDTH-1:0]  cand_q, cand_d;

  logic                          valid_q, valid_d;
  logic                          err_q, err_d;
  logic                          ok_q, ok_d;
  logic [RANGE_INDEX_WIDTH-1:0]  idx_q, idx_d;
  logic signed [VALUE_WIDTH-1:0] start_q, start_d;
  logic signed [VALUE_WIDTH-1:0] end_q, end_d;

  logic [CW-1:0]                 cnt_q       [NUM_VARIABLES];
  logic [CW-1:0]                 cnt_d       [NUM_VARIABLES];
  logic signed [VALUE_WIDTH-1:0] start_tab_q [NUM_VARIABLES][MAX_RANGES];
  logic signed [VALUE_WIDTH-1:0] start_tab_d [NUM_VARIABLES][MAX_RANGES];
  logic signed [VALUE_WIDTH-1:0] end_tab_q   [NUM_VARIABLES][MAX_RANGES];
  logic signed [VALUE_WIDTH-1:0] end_tab_d   [NUM_VARIABLES][MAX_RANGES];

  logic accept, table_wr_en, var_ok, wr_var_ok;
  logic st_lookup, st_draw, st_done;
  logic excl_active, cand_reject, retries_spent, draw_accept;
  logic [RANGE_INDEX_WIDTH-1:0] draw_cand, fallback_idx, draw_pick;

  // A request in IDLE takes priority; seed loads and table writes only land when none is present.
  assign accept      = (state_q == S_IDLE) && in_request;
  assign table_wr_en = (state_q == S_IDLE) && !in_request;
  assign var_ok      = {1'b0, in_variable_index} < VAR_LIMIT;
  assign wr_var_ok   = {1'b0, in_write_variable} < VAR_LIMIT;

  // Exclusion only matters when another legal index exists; with a single range it is waived.
  assign excl_active   = mode_q && (count_q > CW'(1));
  assign draw_cand     = lfsr_q[RANGE_INDEX_WIDTH-1:0];
  assign cand_reject   = ({1'b0, draw_cand} >= count_q) || (excl_active && (draw_cand == cur_q));
  assign retries_spent = (retry_q == RETRY_LIMIT);
  assign fallback_idx  = (excl_active && (cur_q == '0)) ? RANGE_INDEX_WIDTH'(1) : '0;
  assign draw_pick     = retries_spent ? fallback_idx : draw_cand;
  assign draw_accept   = retries_spent || !cand_reject;

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_request) state_d = S_LOOKUP;
      S_LOOKUP: state_d = (count_q == '0) ? S_DONE : S_DRAW;
      S_DRAW:   if (draw_accept) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_busy  = (state_q != S_IDLE);
    st_lookup = (state_q == S_LOOKUP);
    st_draw   = (state_q == S_DRAW);
    st_done   = (state_q == S_DONE);
  end

  always_comb begin
    lfsr_d  = lfsr_q;
    var_d   = var_q;
    mode_d  = mode_q;
    cur_d   = cur_q;
    count_d = count_q;
    retry_d = retry_q;
    cand_d  = cand_q;
    valid_d = 1'b0;
    err_d   = err_q;
    ok_d    = ok_q;
    idx_d   = idx_q;
    start_d = start_q;
    end_d   = end_q;

    if (accept) begin
      var_d   = in_variable_index;
      mode_d  = in_exclude_current;
      cur_d   = in_current_index;
      count_d = var_ok ? cnt_q[in_variable_index] : '0;
    end

    if (table_wr_en && in_seed_load) lfsr_d = (in_seed == '0) ? LFSR_SEED : in_seed;

    if (st_lookup) retry_d = '0;

    // The LFSR steps on every DRAW cycle, including the fallback one, and never elsewhere.
    if (st_draw) begin
      lfsr_d = lfsr_next(lfsr_q);
      cand_d = draw_pick;
      if (!draw_accept) retry_d = retry_q + 1'b1;
    end

    if (st_done) begin
      valid_d = 1'b1;
      if (count_q == '0) begin
        err_d   = 1'b1;
        ok_d    = 1'b0;
        idx_d   = '0;
        start_d = '0;
        end_d   = '0;
      end else begin
        err_d   = 1'b0;
        ok_d    = 1'b1;
        idx_d   = cand_q;
        start_d = start_tab_q[var_q][cand_q];
        end_d   = end_tab_q[var_q][cand_q];
      end
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    start_tab_d = start_tab_q;
    end_tab_d   = end_tab_q;
    if (table_wr_en && in_size_write && wr_var_ok)
      cnt_d[in_write_variable] = sat_count(in_size_value);
    if (table_wr_en && in_range_write && wr_var_ok) begin
      start_tab_d[in_write_variable][in_write_range] = in_write_start;
      end_tab_d[in_write_variable][in_write_range]   = in_write_end;
    end
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      lfsr_q  <= LFSR_SEED;
      var_q   <= '0;
      mode_q  <= 1'b0;
      cur_q   <= '0;
      count_q <= '0;
      retry_q <= '0;
      cand_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ok_q    <= 1'b0;
      idx_q   <= '0;
      start_q <= '0;
      end_q   <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      var_q   <= var_d;
      mode_q  <= mode_d;
      cur_q   <= cur_d;
      count_q <= count_d;
      retry_q <= retry_d;
      cand_q  <= cand_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ok_q    <= ok_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      end_q   <= end_d;
    end
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      for (int v = 0; v < NUM_VARIABLES; v++) begin
        cnt_q[v] <= '0;
        for (int r = 0; r < MAX_RANGES; r++) begin
          start_tab_q[v][r] <= '0;
          end_tab_q[v][r]   <= '0;
        end
      end
    end else begin
      cnt_q       <= cnt_d;
      start_tab_q <= start_tab_d;
      end_tab_q   <= end_tab_d;
    end
  end

  // Equality is only meaningful for a real result; after reset or an error it stays low.
  assign out_valid       = valid_q;
  assign out_error       = err_q;
  assign out_range_index = idx_q;
  assign out_start       = start_q;
  assign out_end         = end_q;
  assign out_equal       = ok_q && (start_q == end_q);

endmodule
